fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FSM state encoding, default no-op word and PC step live here.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD_DEF = 32'h2300_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single output slot, one-entry skid register and redirect handling.
// Optional macro FETCH_PERF_CNT_EN adds a saturating bubble counter output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      DBITS    = 32,
    parameter logic [DBITS-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [DBITS-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [DBITS-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [DBITS-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [DBITS-1:0] imem_data_i,
    output logic [DBITS-1:0] incPC_F,
    output logic [DBITS-1:0] instWord_F,
    output logic             noop_F
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      bubble_cnt_o
`endif
);

    localparam logic [DBITS-1:0] STEP = DBITS'(PC_STEP);

    fetch_state_e     state_r, state_s;
    logic [DBITS-1:0] pc_r, pc_s;
    logic             valid_r, valid_s;
    logic [DBITS-1:0] inst_r, inst_s;
    logic [DBITS-1:0] incpc_r, incpc_s;
    logic [DBITS-1:0] skid_inst_r, skid_inst_s;
    logic [DBITS-1:0] skid_incpc_r, skid_incpc_s;
    logic             req_r, req_s;
    logic             slot_free_s;
    logic [DBITS-1:0] pc_next_s;

    assign slot_free_s = ~valid_r | ~stall_i;
    assign pc_next_s   = pc_r + STEP;

    // Next-state, PC, slot and skid update logic.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        incpc_s      = incpc_r;
        skid_inst_s  = skid_inst_r;
        skid_incpc_s = skid_incpc_r;
        // An unstalled edge consumes a valid slot; it refills below if data is ready.
        if (valid_r && !stall_i) begin
            valid_s = 1'b0;
            inst_s  = NOP_WORD;
        end else begin
            valid_s = valid_r;
            inst_s  = inst_r;
        end

        if (redirect_i) begin
            pc_s    = redirect_pc_i;
            valid_s = 1'b0;
            inst_s  = NOP_WORD;
            case (state_r)
                REQ:     state_s = imem_ack_i ? REQ : DRAIN;
                DRAIN:   state_s = imem_ack_i ? REQ : DRAIN;
                default: state_s = REQ;
            endcase
        end else begin
            case (state_r)
                IDLE: state_s = REQ;
                REQ: begin
                    if (imem_ack_i) begin
                        pc_s = pc_next_s;
                        if (slot_free_s) begin
                            valid_s = 1'b1;
                            inst_s  = imem_data_i;
                            incpc_s = pc_next_s;
                        end else begin
                            skid_inst_s  = imem_data_i;
                            skid_incpc_s = pc_next_s;
                            state_s      = HOLD;
                        end
                    end else begin
                        state_s = REQ;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        valid_s = 1'b1;
                        inst_s  = skid_inst_r;
                        incpc_s = skid_incpc_r;
                        state_s = REQ;
                    end else begin
                        state_s = HOLD;
                    end
                end
                DRAIN: begin
                    if (imem_ack_i) begin
                        state_s = REQ;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: state_s = IDLE;
            endcase
        end

        req_s = (state_s == REQ) || (state_s == DRAIN);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            valid_r      <= 1'b0;
            inst_r       <= NOP_WORD;
            incpc_r      <= '0;
            skid_inst_r  <= NOP_WORD;
            skid_incpc_r <= '0;
            req_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            valid_r      <= valid_s;
            inst_r       <= inst_s;
            incpc_r      <= incpc_s;
            skid_inst_r  <= skid_inst_s;
            skid_incpc_r <= skid_incpc_s;
            req_r        <= req_s;
        end
    end

    assign imem_req_o  = req_r;
    assign imem_addr_o = pc_r;
    assign incPC_F     = incpc_r;
    assign instWord_F  = inst_r;
    assign noop_F      = ~valid_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;

    // Saturating count of unstalled edges with no valid instruction presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_r <= 32'd0;
        end else if (!valid_r && !stall_i && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 32'd1;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign bubble_cnt_o = bubble_cnt_r;
`endif

endmodule
